// File: rtl/axi4lite_wr_arb2.sv
// Two-requester AXI4-Lite write arbiter: grants one requester at a time onto a shared
// downstream write port, alternating on contention, one transaction outstanding.
module axi4lite_wr_arb2 #(
    parameter int AWADDR_WIDTH = 32,
    parameter int DATA_WIDTH   = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [2*AWADDR_WIDTH-1:0]   m_awaddr,
    input  logic [1:0]                  m_awvalid,
    output logic [1:0]                  m_awready,
    input  logic [2*DATA_WIDTH-1:0]     m_wdata,
    input  logic [2*DATA_WIDTH/8-1:0]   m_wstrb,
    input  logic [1:0]                  m_wvalid,
    output logic [1:0]                  m_wready,
    output logic [3:0]                  m_bresp,
    output logic [1:0]                  m_bvalid,
    input  logic [1:0]                  m_bready,
    output logic [AWADDR_WIDTH-1:0]     s_awaddr,
    output logic                        s_awvalid,
    input  logic                        s_awready,
    output logic [DATA_WIDTH-1:0]       s_wdata,
    output logic [DATA_WIDTH/8-1:0]     s_wstrb,
    output logic                        s_wvalid,
    input  logic                        s_wready,
    input  logic [1:0]                  s_bresp,
    input  logic                        s_bvalid,
    output logic                        s_bready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   gnt_q, gnt_d;
    logic   last_gnt_q, last_gnt_d;
    logic   aw_done_q, aw_done_d;
    logic   w_done_q, w_done_d;

    // State register; last_gnt resets to 1 so requester 0 wins the first contention
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

    // Next-state and pass-through routing; every output is forced to 0 while rst is high
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        m_awready  = 2'b00;
        m_wready   = 2'b00;
        m_bresp    = 4'b0000;
        m_bvalid   = 2'b00;
        s_awaddr   = {AWADDR_WIDTH{1'b0}};
        s_awvalid  = 1'b0;
        s_wdata    = {DATA_WIDTH{1'b0}};
        s_wstrb    = {STRB_WIDTH{1'b0}};
        s_wvalid   = 1'b0;
        s_bready   = 1'b0;
        if (rst) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (m_awvalid != 2'b00) begin
                        gnt_d   = (m_awvalid == 2'b11) ? ~last_gnt_q : m_awvalid[1];
                        state_d = XFER;
                    end else begin
                        state_d = IDLE;
                    end
                end
                XFER: begin
                    if (!aw_done_q) begin
                        s_awaddr  = gnt_q ? m_awaddr[2*AWADDR_WIDTH-1:AWADDR_WIDTH]
                                          : m_awaddr[AWADDR_WIDTH-1:0];
                        s_awvalid = m_awvalid[gnt_q];
                        m_awready[gnt_q] = s_awready;
                    end else begin
                        s_awvalid = 1'b0;
                    end
                    if (!w_done_q) begin
                        s_wdata  = gnt_q ? m_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                         : m_wdata[DATA_WIDTH-1:0];
                        s_wstrb  = gnt_q ? m_wstrb[2*STRB_WIDTH-1:STRB_WIDTH]
                                         : m_wstrb[STRB_WIDTH-1:0];
                        s_wvalid = m_wvalid[gnt_q];
                        m_wready[gnt_q] = s_wready;
                    end else begin
                        s_wvalid = 1'b0;
                    end
                    aw_done_d = aw_done_q | (s_awvalid & s_awready);
                    w_done_d  = w_done_q | (s_wvalid & s_wready);
                    if (aw_done_d && w_done_d) begin
                        state_d = RESP;
                    end else begin
                        state_d = XFER;
                    end
                end
                RESP: begin
                    m_bvalid[gnt_q] = s_bvalid;
                    if (gnt_q) begin
                        m_bresp[3:2] = s_bresp;
                    end else begin
                        m_bresp[1:0] = s_bresp;
                    end
                    s_bready = m_bready[gnt_q];
                    if (s_bvalid && s_bready) begin
                        state_d    = IDLE;
                        last_gnt_d = gnt_q;
                        aw_done_d  = 1'b0;
                        w_done_d   = 1'b0;
                    end else begin
                        state_d = RESP;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4lite_wr_arb2.sv
// Scoreboard bench for axi4lite_wr_arb2: requester/slave models driven per cycle,
// expected AW/W/B beats queued at issue time and checked at each handshake.
module tb_axi4lite_wr_arb2;

    logic         clk;
    logic         rst;
    logic [63:0]  m_awaddr;
    logic [1:0]   m_awvalid;
    logic [1:0]   m_awready;
    logic [127:0] m_wdata;
    logic [15:0]  m_wstrb;
    logic [1:0]   m_wvalid;
    logic [1:0]   m_wready;
    logic [3:0]   m_bresp;
    logic [1:0]   m_bvalid;
    logic [1:0]   m_bready;
    logic [31:0]  s_awaddr;
    logic         s_awvalid;
    logic         s_awready;
    logic [63:0]  s_wdata;
    logic [7:0]   s_wstrb;
    logic         s_wvalid;
    logic         s_wready;
    logic [1:0]   s_bresp;
    logic         s_bvalid;
    logic         s_bready;

    typedef struct {
        int          id;
        logic [31:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
        logic [1:0]  bresp;
    } exp_t;

    exp_t aw_q[$];
    exp_t w_q[$];
    exp_t b_q[$];

    int   n_cmp = 0;
    int   n_err = 0;
    logic slv_aw;
    logic slv_w;
    logic [1:0] slv_bresp;
    logic all_zero;

    assign all_zero = ~|{m_awready, m_wready, m_bresp, m_bvalid, s_awaddr, s_awvalid,
                         s_wdata, s_wstrb, s_wvalid, s_bready};

    axi4lite_wr_arb2 #(.AWADDR_WIDTH(32), .DATA_WIDTH(64)) dut (
        .clk(clk), .rst(rst),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: scoreboard checks on pre-edge handshakes, then requester/slave model update.
    task automatic cycle();
        logic [1:0] hs_aw, hs_w, hs_b;
        logic       saw, sw, sb;
        exp_t       e;
        @(posedge clk);
        hs_aw = m_awvalid & m_awready;
        hs_w  = m_wvalid & m_wready;
        hs_b  = m_bvalid & m_bready;
        saw   = s_awvalid & s_awready;
        sw    = s_wvalid & s_wready;
        sb    = s_bvalid & s_bready;
        if (!rst) begin
            if (saw) begin
                n_cmp++;
                if (aw_q.size() == 0) begin
                    n_err++; $display("FAIL sb_aw_unexpected: got addr %0h expected no AW", s_awaddr);
                end else begin
                    e = aw_q.pop_front();
                    if ({s_awaddr, hs_aw} !== {e.addr, (e.id == 0) ? 2'b01 : 2'b10}) begin
                        n_err++; $display("FAIL sb_aw: got addr %0h hs %b expected addr %0h req %0d",
                                          s_awaddr, hs_aw, e.addr, e.id);
                    end
                end
            end
            if (sw) begin
                n_cmp++;
                if (w_q.size() == 0) begin
                    n_err++; $display("FAIL sb_w_unexpected: got data %0h expected no W", s_wdata);
                end else begin
                    e = w_q.pop_front();
                    if ({s_wdata, s_wstrb, hs_w} !== {e.data, e.strb, (e.id == 0) ? 2'b01 : 2'b10}) begin
                        n_err++; $display("FAIL sb_w: got %0h/%0h hs %b expected %0h/%0h req %0d",
                                          s_wdata, s_wstrb, hs_w, e.data, e.strb, e.id);
                    end
                end
            end
            if (hs_b != 2'b00) begin
                n_cmp++;
                if (b_q.size() == 0) begin
                    n_err++; $display("FAIL sb_b_unexpected: got bvalid %b expected none", hs_b);
                end else begin
                    e = b_q.pop_front();
                    if ({hs_b, m_bresp} !== {(e.id == 0) ? 2'b01 : 2'b10,
                                             (e.id == 0) ? {2'b00, e.bresp} : {e.bresp, 2'b00}}) begin
                        n_err++; $display("FAIL sb_b: got hs %b bresp %b expected req %0d bresp %b",
                                          hs_b, m_bresp, e.id, e.bresp);
                    end
                end
            end
        end
        #1;
        m_awvalid = m_awvalid & ~hs_aw;
        m_wvalid  = m_wvalid & ~hs_w;
        if (saw) slv_aw = 1'b1;
        if (sw)  slv_w  = 1'b1;
        if (sb)  s_bvalid = 1'b0;
        if (slv_aw && slv_w && !s_bvalid) begin
            s_bvalid = 1'b1;
            s_bresp  = slv_bresp;
            slv_aw   = 1'b0;
            slv_w    = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic issue(input int id, input logic [31:0] addr, input logic [63:0] data,
                         input logic [7:0] strb, input bit drive_aw);
        exp_t e;
        e.id = id; e.addr = addr; e.data = data; e.strb = strb; e.bresp = slv_bresp;
        if (id == 0) begin
            m_awaddr[31:0] = addr; m_wdata[63:0] = data; m_wstrb[7:0] = strb;
            m_awvalid[0] = drive_aw; m_wvalid[0] = 1'b1;
        end else begin
            m_awaddr[63:32] = addr; m_wdata[127:64] = data; m_wstrb[15:8] = strb;
            m_awvalid[1] = drive_aw; m_wvalid[1] = 1'b1;
        end
        aw_q.push_back(e); w_q.push_back(e); b_q.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && b_q.size() != 0; i++) cycle();
        n_cmp++;
        if (b_q.size() != 0) begin
            n_err++; $display("FAIL %s_timeout: got %0d pending expected 0", name, b_q.size());
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_awaddr = '0; m_awvalid = 2'b00; m_wdata = '0; m_wstrb = '0; m_wvalid = 2'b00;
        m_bready = 2'b11; s_awready = 1'b1; s_wready = 1'b1; s_bresp = 2'b00; s_bvalid = 1'b1;
        slv_aw = 1'b0; slv_w = 1'b0; slv_bresp = 2'b00;
        cycle();
        cycle();
        n_cmp++;
        if (all_zero !== 1'b1) begin
            n_err++; $display("FAIL reset_outputs: got nonzero outputs expected all 0");
        end
        rst = 1'b0;
        cycle();
        n_cmp++;
        if (all_zero !== 1'b1) begin
            n_err++; $display("FAIL post_reset_idle: got nonzero outputs (s_bready %b) expected all 0", s_bready);
        end
        s_bvalid = 1'b0;
    endtask

    task automatic test_single_write();
        slv_bresp = 2'b00;
        issue(0, 32'h10, 64'h1122334455667788, 8'hFF, 1'b1);
        #1;
        n_cmp++;
        if (s_awvalid !== 1'b0) begin
            n_err++; $display("FAIL single_no_early_grant: got s_awvalid %b expected 0", s_awvalid);
        end
        cycle();
        n_cmp++;
        if ({s_awvalid, s_awaddr} !== {1'b1, 32'h10}) begin
            n_err++; $display("FAIL single_aw_pass: got %b/%0h expected 1/10", s_awvalid, s_awaddr);
        end
        for (int i = 0; i < 20 && b_q.size() != 0; i++) begin
            cycle();
            n_cmp++;
            if (m_bvalid[1] !== 1'b0) begin
                n_err++; $display("FAIL single_no_b1: got m_bvalid[1] %b expected 0", m_bvalid[1]);
            end
        end
        drain("single");
    endtask

    task automatic test_back_to_back();
        int   starts[$];
        int   cyc;
        logic prev;
        reset_dut();
        for (int r = 0; r < 2; r++) begin
            starts.delete();
            cyc = 0;
            prev = 1'b0;
            issue(0, 32'h100 + 32'(32 * r), 64'hA0 + 64'(r), 8'h0F, 1'b1);
            issue(1, 32'h110 + 32'(32 * r), 64'hB0 + 64'(r), 8'hF0, 1'b1);
            for (int i = 0; i < 30 && b_q.size() != 0; i++) begin
                cycle();
                cyc++;
                if (s_awvalid && !prev) starts.push_back(cyc);
                prev = s_awvalid;
            end
            drain("b2b");
            n_cmp++;
            if (starts.size() != 2) begin
                n_err++; $display("FAIL b2b_grants: got %0d grants expected 2", starts.size());
            end else if (starts[1] - starts[0] != 3) begin
                n_err++; $display("FAIL b2b_spacing: got %0d cycles expected 3", starts[1] - starts[0]);
            end
        end
    endtask

    task automatic test_w_before_aw();
        s_awready = 1'b0;
        issue(1, 32'h300, 64'hDEADBEEFCAFEF00D, 8'h3C, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_cmp++;
            if ({s_wvalid, m_wready} !== 3'b000) begin
                n_err++; $display("FAIL wfirst_no_grant: got s_wvalid %b m_wready %b expected 0/00", s_wvalid, m_wready);
            end
        end
        m_awvalid[1] = 1'b1;
        cycle();
        n_cmp++;
        if ({s_wvalid, s_awvalid, m_wready} !== 4'b1110) begin
            n_err++; $display("FAIL wfirst_xfer: got w %b aw %b m_wready %b expected 1/1/10", s_wvalid, s_awvalid, m_wready);
        end
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_cmp++;
            if ({s_bready, s_wvalid, s_awvalid} !== 3'b001) begin
                n_err++; $display("FAIL wfirst_wait_aw: got bready %b w %b aw %b expected 0/0/1", s_bready, s_wvalid, s_awvalid);
            end
        end
        s_awready = 1'b1;
        cycle();
        n_cmp++;
        if (s_bready !== 1'b1) begin
            n_err++; $display("FAIL wfirst_resp: got s_bready %b expected 1", s_bready);
        end
        drain("wfirst");
    endtask

    task automatic test_bresp_hold();
        slv_bresp = 2'b10;
        m_bready = 2'b00;
        issue(0, 32'h400, 64'h0123456789ABCDEF, 8'h81, 1'b1);
        for (int i = 0; i < 10 && !m_bvalid[0]; i++) cycle();
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({m_bvalid, m_bresp, s_bready} !== {2'b01, 4'b0010, 1'b0}) begin
                n_err++; $display("FAIL bresp_hold: got bvalid %b bresp %b bready %b expected 01/0010/0",
                                  m_bvalid, m_bresp, s_bready);
            end
            cycle();
        end
        m_bready = 2'b01;
        drain("bresp");
        m_bready = 2'b11;
        slv_bresp = 2'b00;
    endtask

    task automatic test_rst_mid();
        s_wready = 1'b0;
        issue(0, 32'h500, 64'h5555, 8'h01, 1'b1);
        cycle();
        cycle();
        n_cmp++;
        if ({s_awvalid, s_wvalid} !== 2'b01) begin
            n_err++; $display("FAIL rstmid_aw_done: got aw %b w %b expected 0/1", s_awvalid, s_wvalid);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (all_zero !== 1'b1) begin
            n_err++; $display("FAIL rstmid_during: got nonzero outputs expected all 0");
        end
        cycle();
        rst = 1'b0;
        m_awvalid = 2'b00; m_wvalid = 2'b00; s_bvalid = 1'b0; slv_aw = 1'b0; slv_w = 1'b0;
        s_wready = 1'b1;
        aw_q.delete(); w_q.delete(); b_q.delete();
        #1;
        n_cmp++;
        if (all_zero !== 1'b1) begin
            n_err++; $display("FAIL rstmid_after: got nonzero outputs expected all 0");
        end
        issue(0, 32'h600, 64'h6060, 8'hC3, 1'b1);
        issue(1, 32'h610, 64'h6161, 8'h3C, 1'b1);
        cycle();
        n_cmp++;
        if ({s_awaddr, m_awready} !== {32'h600, 2'b01}) begin
            n_err++; $display("FAIL rstmid_regrant: got %0h/%b expected 600/01", s_awaddr, m_awready);
        end
        drain("rstmid");
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_w_before_aw();
        test_bresp_hold();
        test_rst_mid();
        n_cmp++;
        if (aw_q.size() + w_q.size() + b_q.size() != 0) begin
            n_err++; $display("FAIL sb_leftover: got %0d queued expected 0", aw_q.size() + w_q.size() + b_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
